// File: rtl/kda_req_packer.sv
// -----------------------------------------------------------------------------
// kda_req_packer
//   Upstream feeder for the kda top. Captures one parallel PBKDF2 request and
//   serializes it as 17 x 64-bit beats on a valid/ready stream:
//     beat 0     : {chunks[1:0], salt_len[5:0], iters[31:0], 24'b0}
//     beats 1..8 : password, most-significant 64 bits first
//     beats 9..16: salt, most-significant 64 bits first
//   Only one request is held at a time. v_i seen while a request is being sent
//   is ignored, not queued.
//
// Ports
//   clk_i       in   1    clock
//   reset_i     in   1    asynchronous active-high reset
//   chunks_i    in   2    output size select (0..3 -> 32/64/96/128 B)
//   salt_len_i  in   6    salt length in bytes
//   iters_i     in   32   PBKDF2 iteration count
//   pass_i      in   512  password, byte 0 in [511:504]
//   salt_i      in   512  salt, byte 0 in [511:504]
//   v_i         in   1    request valid
//   ready_o     out  1    request accepted when v_i & ready_o
//   data_o      out  64   serialized beat
//   v_o         out  1    beat valid
//   ready_i     in   1    beat consumed when v_o & ready_i
//   busy_o      out  1    request held / being sent
//   err_o       out  1    one-cycle reject pulse
//
// Build option
//   KDA_REQ_CHECK_EN : when defined, requests with iters_i==0 or salt_len_i>60
//                      are consumed but rejected (err_o pulses, nothing sent).
//                      When undefined every accepted request is sent and
//                      err_o is tied low.
// -----------------------------------------------------------------------------
module kda_req_packer (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [1:0]   chunks_i,
   input  logic [5:0]   salt_len_i,
   input  logic [31:0]  iters_i,
   input  logic [511:0] pass_i,
   input  logic [511:0] salt_i,
   input  logic         v_i,
   output logic         ready_o,
   output logic [63:0]  data_o,
   output logic         v_o,
   input  logic         ready_i,
   output logic         busy_o,
   output logic         err_o
);

   localparam int BEATS = 17;
   localparam int CNT_W = 5;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         chunks_q;
   logic [5:0]         salt_len_q;
   logic [31:0]        iters_q;
   logic [511:0]       pass_q;
   logic [511:0]       salt_q;

   logic               accept;
   logic               beat_done;
   logic               last_beat;
   logic               reject;
   logic [63:0]        beats [BEATS];

   // ready_o is gated by reset_i directly so no request can be taken while
   // reset is held, even though the state register already reads IDLE.
   assign ready_o   = (state_q == IDLE) & ~reset_i;
   assign v_o       = (state_q == SEND);
   assign busy_o    = v_o;
   assign accept    = v_i & ready_o;
   assign beat_done = v_o & ready_i;
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef KDA_REQ_CHECK_EN
   logic err_q;

   // Salt lengths above 60 leave no room for the 4-byte block index.
   assign reject = (iters_i == 32'd0) || (salt_len_i > 6'd60);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept & reject;
      end
   end

   assign err_o = err_q;
`else
   assign reject = 1'b0;
   assign err_o  = 1'b0;
`endif

   // Beat table built from the held request; the counter selects one entry.
   assign beats[0] = {chunks_q, salt_len_q, iters_q, 24'b0};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_beats
         assign beats[1 + gi] = pass_q[511 - 64*gi -: 64];
         assign beats[9 + gi] = salt_q[511 - 64*gi -: 64];
      end
   endgenerate

   // Contents only move when a beat is consumed, so data_o holds while stalled.
   assign data_o = v_o ? beats[cnt_q] : 64'd0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept && !reject) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (beat_done) begin
               if (last_beat) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         chunks_q   <= '0;
         salt_len_q <= '0;
         iters_q    <= '0;
         pass_q     <= '0;
         salt_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Fields are sampled only on the accept cycle.
         if (accept) begin
            chunks_q   <= chunks_i;
            salt_len_q <= salt_len_i;
            iters_q    <= iters_i;
            pass_q     <= pass_i;
            salt_q     <= salt_i;
         end
      end
   end

endmodule
